// File: rtl/snd_cmd_mailbox_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snd_cmd_mailbox_if : main-CPU -> sound-CPU command bus (write/pop/NMI)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface snd_cmd_mailbox_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             nmi;
  logic             int_ack;
  logic             overflow;
  logic             overflow_clr;

  modport master (
    output wr_en, wr_data, rd_en, int_ack, overflow_clr,
    input  rd_data, empty, full, count, nmi, overflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, int_ack, overflow_clr,
    output rd_data, empty, full, count, nmi, overflow
  );
endinterface
`default_nettype wire

// File: rtl/snd_cmd_mailbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snd_cmd_mailbox : command FIFO (or legacy one-byte latch) with NMI       |
// | request/acknowledge handshake towards the sound CPU.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module snd_cmd_mailbox #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int LEGACY    = 0,
  parameter int NMI_REARM = 1
) (
  input  wire logic        clk_sys,
  input  wire logic        reset_n,
  snd_cmd_mailbox_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ACKED = 2'd2
  } nmi_state_t;

  nmi_state_t       state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             overflow_q, overflow_d;
  logic             pend_q, pend_d;
  logic             w_acc_wr, w_do_rd, w_trig;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q;
    w_acc_wr   = 1'b0;
    w_do_rd    = 1'b0;
    w_trig     = 1'b0;
    if (LEGACY != 0) begin
      if (bus.wr_en) begin
        rd_data_d = bus.wr_data;
        w_trig    = (bus.wr_data != rd_data_q);
      end
    end else begin
      w_do_rd  = bus.rd_en && (count_q != '0);
      w_acc_wr = bus.wr_en && ((count_q != c_full_cnt) || bus.rd_en);
      if (w_acc_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_do_rd)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(w_acc_wr) - CW'(w_do_rd);
      w_trig  = w_acc_wr && (count_q == '0);
      // Head is refreshed only when it moves; an emptied FIFO keeps the last word.
      if ((w_acc_wr || w_do_rd) && (count_d != '0))
        rd_data_d = (w_acc_wr && (rd_ptr_d == wr_ptr_q)) ? bus.wr_data : mem_q[rd_ptr_d];
      overflow_d = (bus.wr_en && (count_q == c_full_cnt) && !bus.rd_en)
                 || (overflow_q && !bus.overflow_clr);
    end
  end

  // A trigger coinciding with an ack is parked in pend_q and replayed from ACKED.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (w_trig) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.int_ack) begin
          state_d = S_ACKED;
          pend_d  = w_trig;
        end
      end
      S_ACKED: begin
        pend_d = 1'b0;
        if (w_trig || pend_q || ((NMI_REARM != 0) && (count_q != '0)))
          state_d = S_REQ;
        else
          state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_acc_wr) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.empty    = (LEGACY != 0) ? 1'b0 : (count_q == '0);
  assign bus.full     = (LEGACY != 0) ? 1'b0 : (count_q == c_full_cnt);
  assign bus.count    = (LEGACY != 0) ? '0 : count_q;
  assign bus.nmi      = (state_q == S_REQ);
  assign bus.overflow = overflow_q;
endmodule
`default_nettype wire
